// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: turns operation handshakes into 32-bit words,
// buffers them in a small FIFO, and writes them to sequential instruction-memory addresses.
module mips_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   occ;
  logic          full, empty, accept, push, pop, illegal;
  logic [31:0]   enc;

  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    case (in_op)
      4'd0:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      4'd1:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
      4'd2:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
      4'd3:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
      4'd4:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
      4'd5:    enc = {6'h08, in_rs, in_rt, in_imm};
      4'd6:    enc = {6'h23, in_rs, in_rt, in_imm};
      4'd7:    enc = {6'h2B, in_rs, in_rt, in_imm};
      4'd8:    enc = {6'h04, in_rs, in_rt, in_imm};
      4'd9:    enc = {6'h02, in_target};
      4'd10:   enc = {6'h0C, in_rs, in_rt, in_imm};
      4'd11:   enc = {6'h0D, in_rs, in_rt, in_imm};
      4'd12:   enc = {6'h0E, in_rs, in_rt, in_imm};
      4'd13:   enc = {6'h0A, in_rs, in_rt, in_imm};
      default: illegal = 1'b1;
    endcase
  end

  assign full  = (occ == (PW+1)'(FIFO_DEPTH));
  assign empty = (occ == '0);

  // Words already buffered count against the program limit so the FIFO never overshoots it.
  assign in_ready = (state == RUN) && !full &&
                    ((32'(count) + 32'(occ)) < 32'(MAX_WORDS));
  assign wr_en    = !empty && ((state == RUN) || (state == DRAIN));
  assign wr_data  = wr_en ? mem[rd_ptr] : '0;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  assign accept = in_valid && in_ready;
  assign push   = accept && !illegal;
  assign pop    = wr_en && wr_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      wr_addr <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wr_addr <= wr_addr + 32'd4;
        count   <= count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (accept && illegal) err <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            wr_addr <= base_addr;
            count   <= '0;
            err     <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
          end
        end
        RUN: begin
          if (pop && (count == 16'(MAX_WORDS - 1))) state <= DONE;
          else if (finish)                          state <= DRAIN;
        end
        DRAIN: begin
          if ((pop && (count == 16'(MAX_WORDS - 1))) || empty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: default instance for encoding, back-pressure,
// error and reset cases, plus a MAX_WORDS=3 instance for the word limit.
module tb_mips_instr_encoder;

  logic        clk;
  logic        rst, start, finish, in_valid, wr_ready;
  logic [31:0] base_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, wr_en, busy, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] count;

  logic        m_start, m_finish, m_in_valid, m_wr_ready;
  logic [31:0] m_base_addr;
  logic        m_in_ready, m_wr_en, m_busy, m_done, m_err;
  logic [31:0] m_wr_addr, m_wr_data;
  logic [15:0] m_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] log_addr[$], log_data[$];
  int unsigned m_nwr = 0;

  mips_instr_encoder #(.FIFO_DEPTH(4), .MAX_WORDS(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  mips_instr_encoder #(.FIFO_DEPTH(4), .MAX_WORDS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(m_start), .finish(m_finish), .base_addr(m_base_addr),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(4'd0), .in_rs(5'd1),
    .in_rt(5'd2), .in_rd(5'd3), .in_imm(16'h0000), .in_target(26'h0),
    .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data), .wr_ready(m_wr_ready),
    .busy(m_busy), .done(m_done), .err(m_err), .count(m_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Writes that will complete at the coming rising edge
  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (m_wr_en && m_wr_ready) m_nwr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int n = 0;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] addr);
    base_addr = addr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag, input int unsigned idx,
                           input logic [31:0] addr, input logic [31:0] data);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, log_addr[idx], addr);
      check({tag, "_data"}, log_data[idx], data);
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int unsigned lb;
    int unsigned acc;
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    base_addr = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    m_start = 1'b0; m_finish = 1'b0; m_in_valid = 1'b0; m_wr_ready = 1'b1; m_base_addr = 32'h3000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wr_en",    32'(wr_en), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_done",     32'(done), 0);
    check("rst_err",      32'(err), 0);
    check("rst_wr_addr",  wr_addr, 0);
    check("rst_wr_data",  wr_data, 0);
    check("rst_count",    32'(count), 0);

    // Program 1: single ADD, one-cycle latency
    pulse_start(32'h0040_0000);
    check("p1_busy", 32'(busy), 1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    check("p1_wr_en",   32'(wr_en), 1);
    check("p1_wr_addr", wr_addr, 32'h0040_0000);
    check("p1_wr_data", wr_data, 32'h0022_1820);
    @(posedge clk); #1;
    check("p1_count",   32'(count), 1);
    check("p1_addr_inc", wr_addr, 32'h0040_0004);
    pulse_finish();
    wait_done("p1_done");
    check("p1_in_ready", 32'(in_ready), 0);
    check("p1_busy_off", 32'(busy), 0);

    // Program 2: ADDI, LW, J then finish
    pulse_start(32'h0040_0000);
    lb = log_addr.size();
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0);
    send(4'd6, 5'd29, 5'd4, 5'd0, 16'hFFFC, 26'h0);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
    pulse_finish();
    wait_done("p2_done");
    check("p2_in_ready", 32'(in_ready), 0);
    check("p2_wr_en",    32'(wr_en), 0);
    check("p2_count",    32'(count), 3);
    check_log("p2_addi", lb,     32'h0040_0000, 32'h2008_0005);
    check_log("p2_lw",   lb + 1, 32'h0040_0004, 32'h8FA4_FFFC);
    check_log("p2_j",    lb + 2, 32'h0040_0008, 32'h0810_0000);

    // Program 3: back-pressure fills the FIFO
    wr_ready = 1'b0;
    pulse_start(32'h0000_1000);
    lb = log_addr.size();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    send(4'd3, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0);
    @(negedge clk);
    check("p3_full_ready", 32'(in_ready), 0);
    check("p3_hold_en",    32'(wr_en), 1);
    check("p3_hold_data0", wr_data, 32'h0022_1820);
    repeat (3) @(negedge clk);
    check("p3_hold_data1", wr_data, 32'h0022_1820);
    check("p3_hold_addr",  wr_addr, 32'h0000_1000);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(4'd4, 5'd13, 5'd14, 5'd15, 16'h0, 26'h0);
    pulse_finish();
    wait_done("p3_done");
    check("p3_count", 32'(count), 5);
    check_log("p3_w0", lb,     32'h0000_1000, 32'h0022_1820);
    check_log("p3_w1", lb + 1, 32'h0000_1004, 32'h0085_3022);
    check_log("p3_w2", lb + 2, 32'h0000_1008, 32'h00E8_4824);
    check_log("p3_w3", lb + 3, 32'h0000_100C, 32'h014B_6025);
    check_log("p3_w4", lb + 4, 32'h0000_1010, 32'h01AE_782A);

    // Program 4: illegal op sets sticky err, no word pushed
    pulse_start(32'h0000_2000);
    lb = log_addr.size();
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    check("p4_err_set", 32'(err), 1);
    check("p4_no_push", 32'(wr_en), 0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(posedge clk); #1;
    check("p4_count1", 32'(count), 1);
    send(4'd7, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    send(4'd12, 5'd5, 5'd6, 5'd0, 16'h00FF, 26'h0);
    pulse_finish();
    wait_done("p4_done");
    check("p4_count", 32'(count), 4);
    check("p4_err_sticky", 32'(err), 1);
    check_log("p4_add",  lb,     32'h0000_2000, 32'h0022_1820);
    check_log("p4_sw",   lb + 1, 32'h0000_2004, 32'hAC43_0010);
    check_log("p4_beq",  lb + 2, 32'h0000_2008, 32'h1022_FFFF);
    check_log("p4_xori", lb + 3, 32'h0000_200C, 32'h38A6_00FF);

    // Program 5: start clears err, address wraps, then reset mid-run
    pulse_start(32'hFFFF_FFFC);
    check("p5_err_clr",  32'(err), 0);
    check("p5_count0",   32'(count), 0);
    check("p5_base",     wr_addr, 32'hFFFF_FFFC);
    lb = log_addr.size();
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0);
    send(4'd10, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0);
    repeat (3) @(posedge clk);
    #1;
    check_log("p5_wrap0", lb,     32'hFFFF_FFFC, 32'h2008_0005);
    check_log("p5_wrap1", lb + 1, 32'h0000_0000, 32'h3022_1234);
    wr_ready = 1'b0;
    send(4'd11, 5'd3, 5'd4, 5'd0, 16'hABCD, 26'h0);
    check("p5_ori", wr_data, 32'h3464_ABCD);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_in_ready", 32'(in_ready), 0);
    check("mrst_wr_en",    32'(wr_en), 0);
    check("mrst_busy",     32'(busy), 0);
    check("mrst_done",     32'(done), 0);
    check("mrst_wr_addr",  wr_addr, 0);
    check("mrst_wr_data",  wr_data, 0);
    check("mrst_count",    32'(count), 0);
    lb = log_addr.size();
    wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_discard", 32'(log_addr.size()), 32'(lb));

    // MAX_WORDS=3 instance offered 5 ops
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    m_in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_in_valid && m_in_ready) acc++;
      @(posedge clk); #1;
      if (acc >= 5) m_in_valid = 1'b0;
    end
    m_in_valid = 1'b0;
    check("max_accepted", 32'(acc), 3);
    check("max_writes",   32'(m_nwr), 3);
    check("max_count",    32'(m_count), 3);
    check("max_done",     32'(m_done), 1);
    check("max_in_ready", 32'(m_in_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
